// File: rtl/hazard_pkg.sv
// Shared constants for the MIPS pipeline hazard controller: forwarding mux
// select encodings and default widths/latencies.
package hazard_pkg;

   localparam int RA_W_DEF    = 5;
   localparam int MDU_LAT_DEF = 4;
   localparam int CNT_W_DEF   = 3;

   // Forwarding select encodings for the EX-stage operand muxes
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/mdu_busy_ctr.sv
// MUL/DIV in-flight tracker: loads MDU_LAT on a launch, counts down to zero
// and reports busy while nonzero. Reset is synchronous, active-low.
module mdu_busy_ctr
   import hazard_pkg::*;
#(
   parameter int MDU_LAT = MDU_LAT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   output logic o_busy
);

   logic [CNT_W-1:0] r_cnt;

   // Load on launch, otherwise count down to zero (also while frozen)
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CNT_W'(MDU_LAT);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard, forwarding and stall controller for the 5-stage MIPS pipeline.
// Everything is combinational from the inputs and the MDU counter; all
// outputs are forced low while rst_n is low.
// Optional: define HZD_PERF_CNT_EN to add stall/flush/freeze cycle counters.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int RA_W    = RA_W_DEF,
   parameter int MDU_LAT = MDU_LAT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [RA_W-1:0] rs_d,
   input  logic [RA_W-1:0] rt_d,
   input  logic [RA_W-1:0] rs_e,
   input  logic [RA_W-1:0] rt_e,
   input  logic [RA_W-1:0] wreg_e,
   input  logic [RA_W-1:0] wreg_m,
   input  logic [RA_W-1:0] wreg_w,
   input  logic            regwrite_e,
   input  logic            regwrite_m,
   input  logic            regwrite_w,
   input  logic            memtoreg_e,
   input  logic            memtoreg_m,
   input  logic            branch_d,
   input  logic            branch_taken_d,
   input  logic            jump_d,
   input  logic            md_op_d,
   input  logic            hilo_rd_d,
   input  logic            md_start_e,
   input  logic            dmem_req_m,
   input  logic            dmem_ready_m,
   output logic            stall_f,
   output logic            stall_d,
   output logic            stall_e,
   output logic            stall_m,
   output logic            flush_d,
   output logic            flush_e,
   output logic            flush_w,
   output logic [1:0]      fwd_a_e,
   output logic [1:0]      fwd_b_e,
   output logic            fwd_a_d,
   output logic            fwd_b_d,
   output logic            mdu_busy
`ifdef HZD_PERF_CNT_EN
   ,
   output logic [31:0]     perf_stall_cyc,
   output logic [31:0]     perf_flush_cyc,
   output logic [31:0]     perf_freeze_cyc
`endif
);

   // Register 0 is hardwired to zero, so it never creates a dependency
   function automatic logic hit(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
      return (a != '0) && (a == b);
   endfunction

   logic       w_busy;
   logic       w_freeze;
   logic       w_lwstall;
   logic       w_brstall;
   logic       w_mdstall;
   logic       w_ctrl_flush;
   logic [3:0] w_stall;
   logic [2:0] w_flush;
   logic [1:0] w_fwd_a_e;
   logic [1:0] w_fwd_b_e;

   mdu_busy_ctr #(
      .MDU_LAT (MDU_LAT),
      .CNT_W   (CNT_W)
   ) u_mdu_busy_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (md_start_e && !w_freeze),
      .o_busy (w_busy)
   );

   assign w_freeze     = dmem_req_m && !dmem_ready_m;
   assign w_lwstall    = memtoreg_e && (hit(rt_e, rs_d) || hit(rt_e, rt_d));
   assign w_brstall    = branch_d &&
                         ((regwrite_e && (hit(wreg_e, rs_d) || hit(wreg_e, rt_d))) ||
                          (memtoreg_m && (hit(wreg_m, rs_d) || hit(wreg_m, rt_d))));
   assign w_mdstall    = w_busy && (hilo_rd_d || md_op_d);
   assign w_ctrl_flush = jump_d || (branch_d && branch_taken_d);

   // EX forwarding selects, MEM result takes priority over WB
   always_comb begin
      w_fwd_a_e = FWD_RF;
      w_fwd_b_e = FWD_RF;
      if (regwrite_m && hit(wreg_m, rs_e))      w_fwd_a_e = FWD_MEM;
      else if (regwrite_w && hit(wreg_w, rs_e)) w_fwd_a_e = FWD_WB;
      if (regwrite_m && hit(wreg_m, rt_e))      w_fwd_b_e = FWD_MEM;
      else if (regwrite_w && hit(wreg_w, rt_e)) w_fwd_b_e = FWD_WB;
   end

   // Stall/flush priority: freeze, then data/MDU stall, then control flush
   // NOTE: defaults are assigned first so every path drives every output and
   // no latch is inferred.
   always_comb begin
      w_stall = 4'b0000;   // {f, d, e, m}
      w_flush = 3'b000;    // {d, e, w}
      if (w_freeze) begin
         w_stall = 4'b1111;
         w_flush = 3'b001;
      end else if (w_lwstall || w_brstall || w_mdstall) begin
         w_stall = 4'b1100;
         w_flush = 3'b010;
      end else if (w_ctrl_flush) begin
         w_flush = 3'b100;
      end
   end

   assign {stall_f, stall_d, stall_e, stall_m} = rst_n ? w_stall : 4'b0000;
   assign {flush_d, flush_e, flush_w}          = rst_n ? w_flush : 3'b000;
   assign fwd_a_e  = rst_n ? w_fwd_a_e : FWD_RF;
   assign fwd_b_e  = rst_n ? w_fwd_b_e : FWD_RF;
   assign fwd_a_d  = rst_n && regwrite_m && !memtoreg_m && hit(wreg_m, rs_d);
   assign fwd_b_d  = rst_n && regwrite_m && !memtoreg_m && hit(wreg_m, rt_d);
   assign mdu_busy = rst_n && w_busy;

`ifdef HZD_PERF_CNT_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;
   logic [31:0] r_perf_freeze;

   // Free-running wrap-around event counters for stall, flush and freeze cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_stall  <= '0;
         r_perf_flush  <= '0;
         r_perf_freeze <= '0;
      end else begin
         if (stall_d)  r_perf_stall  <= r_perf_stall  + 32'd1;
         if (flush_d)  r_perf_flush  <= r_perf_flush  + 32'd1;
         if (w_freeze) r_perf_freeze <= r_perf_freeze + 32'd1;
      end
   end

   assign perf_stall_cyc  = r_perf_stall;
   assign perf_flush_cyc  = r_perf_flush;
   assign perf_freeze_cyc = r_perf_freeze;
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard, forwarding and stall controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Adds the following over the single-cycle-latency combinational hazard logic:
  - EX-stage and ID-stage (branch compare) forwarding selects.
  - A register-0 exclusion.
  - A variable-latency data-memory freeze.
  - A multi-cycle MUL/DIV busy counter with HI/LO interlock.
- Sits beside the pipeline registers; drives their enables and flush inputs and the forwarding muxes.

Parameters:
- RA_W, 5, register address width.
- MDU_LAT, 4, MUL/DIV unit latency in cycles (>=1).
- CNT_W, 3, MDU counter width (must hold MDU_LAT).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- rs_d  in  RA_W  ID source register rs.
- rt_d  in  RA_W  ID source register rt.
- rs_e  in  RA_W  EX source register rs.
- rt_e  in  RA_W  EX source register rt.
- wreg_e  in  RA_W  EX destination register.
- wreg_m  in  RA_W  MEM destination register.
- wreg_w  in  RA_W  WB destination register.
- regwrite_e  in  1  EX writes the register file.
- regwrite_m  in  1  MEM writes the register file.
- regwrite_w  in  1  WB writes the register file.
- memtoreg_e  in  1  EX instruction is a load.
- memtoreg_m  in  1  MEM instruction is a load.
- branch_d  in  1  ID instruction is a branch.
- branch_taken_d  in  1  ID branch resolved taken.
- jump_d  in  1  ID instruction is a jump.
- md_op_d  in  1  ID instruction is MULT/DIV.
- hilo_rd_d  in  1  ID instruction is MFHI/MFLO.
- md_start_e  in  1  EX launches a MUL/DIV op.
- dmem_req_m  in  1  MEM stage performs a data access.
- dmem_ready_m  in  1  data memory completes the access this cycle.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID.
- stall_e  out  1  hold ID/EX.
- stall_m  out  1  hold EX/MEM.
- flush_d  out  1  clear IF/ID.
- flush_e  out  1  clear ID/EX (bubble).
- flush_w  out  1  clear MEM/WB.
- fwd_a_e  out  2  EX operand A select: 00 regfile, 10 MEM result, 01 WB result.
- fwd_b_e  out  2  EX operand B select, same encoding.
- fwd_a_d  out  1  ID compare A from MEM ALU result.
- fwd_b_d  out  1  ID compare B from MEM ALU result.
- mdu_busy  out  1  MUL/DIV in flight.

Behaviour:
- rst_n low at a clk edge: mdu_cnt<=0. All outputs are gated to 0 while rst_n is low, even mid-operation; the counter state is abandoned.
- No hazard or forward is ever raised on register 0. Every match term requires a nonzero address.
- EX forwarding:
  - fwd_a_e=10 if regwrite_m && wreg_m==rs_e.
  - Otherwise 01 if regwrite_w && wreg_w==rs_e.
  - Otherwise 00. MEM has priority over WB.
  - fwd_b_e uses the same rules on rt_e.
- ID forwarding: fwd_a_d = regwrite_m && !memtoreg_m && wreg_m==rs_d. fwd_b_d uses the same rule on rt_d.
- lwstall = memtoreg_e && (rt_e==rs_d || rt_e==rt_d).
- brstall = branch_d && ((regwrite_e && wreg_e matches rs_d/rt_d) || (memtoreg_m && wreg_m matches rs_d/rt_d)).
- mdstall = mdu_busy && (hilo_rd_d || md_op_d).
- freeze = dmem_req_m && !dmem_ready_m.
- Priority, highest first:
  1. freeze: stall_f/d/e/m=1, flush_w=1, all flushes into earlier stages 0.
  2. lwstall|brstall|mdstall: stall_f=stall_d=1, flush_e=1, flush_d=0.
  3. Jump or taken branch: flush_d=1, no stall.
  4. Otherwise all 0.
- Jumps never stall.
- MDU counter:
  - md_start_e && !freeze loads mdu_cnt<=MDU_LAT.
  - Otherwise, if mdu_cnt!=0, it decrements every cycle, including freeze cycles.
  - mdu_busy = (mdu_cnt!=0).
  - md_start_e while busy reloads the counter. This is legal but should not occur, because mdstall blocks it.
- Latency: all outputs are combinational from inputs and mdu_cnt; only mdu_cnt is registered.
- Example: with MDU_LAT=4, an MFHI issued the cycle after the start stalls 4 cycles.

Optional Feature:
- HZD_PERF_CNT_EN defined: adds outputs perf_stall_cyc [31:0], perf_flush_cyc [31:0] and perf_freeze_cyc [31:0].
  - Each increments by 1 on cycles where stall_d, flush_d or freeze respectively is 1.
  - Each wraps at 2^32 and is cleared by reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd select constants FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
  - default RA_W.
- One sub-module: mdu_busy_ctr (load/decrement counter, busy flag), parametrised by MDU_LAT and CNT_W.

Test Plan:
- Load-use: memtoreg_e=1, rt_e=8, rs_d=8 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; same stimulus with rt_e=0, rs_d=0 -> no stall.
- Forward priority: regwrite_m=regwrite_w=1, wreg_m=wreg_w=rs_e=9 -> fwd_a_e=10; regwrite_m=0 -> fwd_a_e=01.
- Branch after ALU op: branch_d=1, regwrite_e=1, wreg_e=rt_d=5 -> 1-cycle stall; next cycle regwrite_m, wreg_m=5 -> fwd_b_d=1, no stall.
- MDU: md_start_e pulse, then hilo_rd_d=1 held -> mdu_busy and stall_d high for MDU_LAT=4 cycles, low on the 5th.
- Memory freeze: dmem_req_m=1, dmem_ready_m=0 for 3 cycles with concurrent lwstall and jump_d -> stall_f/d/e/m=1 and flush_w=1 for 3 cycles, flush_d=0; reset asserted mid-freeze -> all outputs 0 next cycle.
